// File: rtl/sdram_pkg.sv
// Shared SDRAM user-side definitions: address layout, arbiter states and the
// burst-base alignment helper used by the arbiter and the address generators.
package sdram_pkg;

    localparam int ADDR_W   = 24;
    localparam int BANK_MSB = 23;
    localparam int ROW_LSB  = 9;
    localparam int COL_W    = 9;

    typedef logic [ADDR_W-1:0] sdram_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Truncate the column down to a burst boundary so a burst never leaves its row.
    function automatic sdram_addr_t align_base(input sdram_addr_t a, input int unsigned blen);
        sdram_addr_t r;
        r = a;
        r[COL_W-1:0] = a[COL_W-1:0] & ~COL_W'(blen - 1);
        return r;
    endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-request round-robin pick: a lone request wins outright, a contest goes
// to the port that was not served last.
module sdram_arb_rr (
    input  logic rd_req,
    input  logic wr_req,
    input  logic last_wr,
    output logic grant_rd,
    output logic grant_wr
);

    assign grant_rd = rd_req & (~wr_req | last_wr);
    assign grant_wr = wr_req & (~rd_req | ~last_wr);

endmodule

// File: rtl/sdram_arbiter.sv
// Burst arbiter between camera writes and display reads, owning the single
// request interface of the SDRAM controller.
//
// state | meaning
// IDLE  | waiting for a request; round-robin grant latches base and direction
// BURST | sd_m_valid high, one word per accepted cycle, watchdog running
// GAP   | forced controller recovery, requests ignored
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int BURST_LEN  = 16,
    parameter int GAP_CYCLES = 6,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [23:0]       wr_addr,
    input  logic [15:0]       wr_data,
    output logic              wr_pop,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [23:0]       rd_addr,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic              rd_done,
    output logic              err_timeout,
    output logic              sd_m_valid,
    output logic              sd_m_we,
    output logic [23:0]       sd_m_addr,
    output logic [15:0]       sd_in_data,
    output logic              sd_serial_access,
    input  logic              sd_m_ready,
    input  logic [15:0]       sd_out_data
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    arb_state_e         state_q, state_d;
    sdram_addr_t        base_q, base_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               we_q, we_d;
    logic               valid_q, valid_d;
    logic               wr_done_q, wr_done_d;
    logic               rd_done_q, rd_done_d;
    logic               err_q, err_d;
    logic               last_wr_q, last_wr_d;

    logic               grant_rd, grant_wr;
    logic               xfer;
    logic               end_burst;
    logic [COL_W-1:0]   cnt_col;

    sdram_arb_rr u_rr (
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .last_wr  (last_wr_q),
        .grant_rd (grant_rd),
        .grant_wr (grant_wr)
    );

    assign xfer    = valid_q & sd_m_ready;
    assign cnt_col = COL_W'(cnt_q[CNT_W-2:0]);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        we_d      = we_q;
        valid_d   = valid_q;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        err_d     = err_q;
        last_wr_d = last_wr_q;
        end_burst = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_rd || grant_wr) begin
                    state_d = BURST;
                    valid_d = 1'b1;
                    we_d    = grant_wr;
                    base_d  = align_base(grant_wr ? wr_addr : rd_addr, BURST_LEN);
                    cnt_d   = '0;
                    wdog_d  = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    wdog_d = '0;
                    if (cnt_q == CNT_W'(BURST_LEN - 1))
                        end_burst = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                    if (wdog_d == WD_W'(TIMEOUT)) begin
                        end_burst = 1'b1;
                        err_d     = 1'b1;
                    end
                end
                // A watchdog abort closes the burst exactly like a full one.
                if (end_burst) begin
                    state_d   = GAP;
                    valid_d   = 1'b0;
                    wr_done_d = we_q;
                    rd_done_d = ~we_q;
                    last_wr_d = we_q;
                    gap_d     = GAP_W'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_q == '0)
                    state_d = IDLE;
                else
                    gap_d = gap_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            cnt_q     <= '0;
            wdog_q    <= '0;
            gap_q     <= '0;
            we_q      <= 1'b0;
            valid_q   <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
            we_q      <= we_d;
            valid_q   <= valid_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            err_q     <= err_d;
            last_wr_q <= last_wr_d;
        end
    end

    assign sd_m_valid       = valid_q;
    assign sd_m_we          = we_q;
    assign sd_m_addr        = {base_q[BANK_MSB:ROW_LSB], base_q[COL_W-1:0] | cnt_col};
    assign sd_in_data       = wr_data;
    assign sd_serial_access = 1'b0;
    assign wr_pop           = xfer & we_q;
    assign rd_valid         = xfer & ~we_q;
    assign rd_data          = rd_valid ? sd_out_data : 16'h0000;
    assign wr_done          = wr_done_q;
    assign rd_done          = rd_done_q;
    assign err_timeout      = err_q;

endmodule
